// File: rtl/pattern_det_ctrl.sv
// pattern_det_ctrl: serialises valid/ready words MSB-first and counts runtime-pattern matches per frame.
// Define PDC_STICKY_EN to add the sticky_clr input and sticky_match output.
module pattern_det_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W = 8,
  localparam int LEN_W = $clog2(PAT_MAX + 1),
  localparam int IDX_W = DATA_W > 1 ? $clog2(DATA_W) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_last,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count,
`ifdef PDC_STICKY_EN
  input  logic               sticky_clr,
  output logic               sticky_match,
`endif
  output logic               done,
  output logic               busy
);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [PAT_MAX-1:0] hist, hist_n, pat_q, mask;
  logic [LEN_W-1:0] len_q, seen, seen_n;
  logic [DATA_W-1:0] data_q;
  logic [IDX_W-1:0] idx;
  logic ovl_q, last_q, first_q, hit;
  always_comb begin
    hist_n = (hist << 1) | PAT_MAX'(data_q[idx]);
    seen_n = seen == LEN_W'(PAT_MAX) ? seen : seen + 1'b1;
    mask = ~({PAT_MAX{1'b1}} << len_q);
    hit = state == SHIFT && len_q != '0 && seen_n >= len_q && ((hist_n ^ pat_q) & mask) == '0;
  end
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hist <= '0;
      seen <= '0;
      pat_q <= '0;
      len_q <= '0;
      ovl_q <= 1'b0;
      data_q <= '0;
      idx <= '0;
      last_q <= 1'b0;
      first_q <= 1'b1;
      match_pulse <= 1'b0;
      match_count <= '0;
    end else begin
      match_pulse <= hit;
      if (state == IDLE && cfg_we) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len > LEN_W'(PAT_MAX) ? LEN_W'(PAT_MAX) : cfg_len;
        ovl_q <= cfg_overlap;
      end
      if (state == IDLE && in_valid) begin
        data_q <= in_data;
        last_q <= in_last;
        idx <= IDX_W'(DATA_W - 1);
        state <= SHIFT;
        first_q <= 1'b0;
        if (first_q) match_count <= '0;
      end
      if (state == SHIFT) begin
        hist <= hist_n;
        seen <= hit && !ovl_q ? '0 : seen_n;
        idx <= idx - 1'b1;
        if (idx == '0) state <= last_q ? DONE : IDLE;
        if (hit && match_count != '1) match_count <= match_count + 1'b1;
      end
      if (state == DONE) begin
        hist <= '0;
        seen <= '0;
        first_q <= 1'b1;
        state <= IDLE;
      end
    end
  end
`ifdef PDC_STICKY_EN
  always_ff @(posedge clk) begin
    if (reset) sticky_match <= 1'b0;
    else sticky_match <= hit | (sticky_match & ~sticky_clr);
  end
`endif
endmodule

// File: tb/tb_pattern_det_ctrl.sv
// tb_pattern_det_ctrl: directed scoreboard bench for pattern_det_ctrl (8-bit counter and a 2-bit saturating copy).
module tb_pattern_det_ctrl;
  logic clk = 0, reset = 1, cfg_we = 0, cfg_overlap = 0, in_valid = 0, in_last = 0;
  logic [7:0] cfg_pattern = 0, in_data = 0;
  logic [3:0] cfg_len = 0;
  logic in_ready, match_pulse, done, busy;
  logic in_ready2, match_pulse2, done2, busy2;
  logic [7:0] match_count;
  logic [1:0] match_count2;
  int errors = 0, checks = 0;
  logic [7:0] m_hist = 0, m_pat = 0;
  int m_seen = 0, m_len = 0, m_count = 0, m_count2 = 0;
  bit m_ovl = 0, m_first = 1;
  bit q_pulse[$];
`ifdef PDC_STICKY_EN
  logic sticky_clr = 0, sticky_match, sticky_match2;
`endif

  pattern_det_ctrl dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .match_pulse(match_pulse), .match_count(match_count),
`ifdef PDC_STICKY_EN
    .sticky_clr(sticky_clr), .sticky_match(sticky_match),
`endif
    .done(done), .busy(busy));

  pattern_det_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_last(in_last), .match_pulse(match_pulse2), .match_count(match_count2),
`ifdef PDC_STICKY_EN
    .sticky_clr(sticky_clr), .sticky_match(sticky_match2),
`endif
    .done(done2), .busy(busy2));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [7:0] p, input int len, input bit ovl);
    cfg_we = 1;
    cfg_pattern = p;
    cfg_len = 4'(len);
    cfg_overlap = ovl;
    tick();
    cfg_we = 0;
    m_pat = p;
    m_len = len > 8 ? 8 : len;
    m_ovl = ovl;
  endtask

  task automatic model_bit(input bit b, output bit p);
    logic [7:0] mask;
    m_hist = {m_hist[6:0], b};
    m_seen = m_seen < 8 ? m_seen + 1 : 8;
    mask = m_len >= 8 ? 8'hFF : 8'((1 << m_len) - 1);
    p = m_len != 0 && m_seen >= m_len && (m_hist & mask) == (m_pat & mask);
    if (p) begin
      if (m_count < 255) m_count++;
      if (m_count2 < 3) m_count2++;
      if (!m_ovl) m_seen = 0;
    end
  endtask

  task automatic send_word(input logic [7:0] d, input bit last, input int exp_cnt, input bit bad_cfg = 0);
    bit p;
    chk("ready_idle", in_ready, 1);
    in_valid = 1;
    in_data = d;
    in_last = last;
    if (m_first) begin
      m_count = 0;
      m_count2 = 0;
      m_first = 0;
    end
    for (int k = 7; k >= 0; k--) begin
      model_bit(d[k], p);
      q_pulse.push_back(p);
    end
    tick();
    in_valid = 0;
    in_data = ~d;
    in_last = ~last;
    if (bad_cfg) begin
      cfg_we = 1;
      cfg_pattern = 8'hFF;
      cfg_len = 1;
      cfg_overlap = 1;
    end
    chk("ready_shift", in_ready, 0);
    chk("busy_shift", busy, 1);
    chk("pulse_t1", match_pulse, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      cfg_we = 0;
      chk("match_pulse", match_pulse, q_pulse.pop_front());
      chk("done", done, k == 7 && last);
      chk("ready", in_ready, k == 7 && !last);
    end
    chk("match_count", match_count, m_count);
    chk("match_count_sat", match_count2, m_count2);
    if (exp_cnt >= 0) chk("count_plan", match_count, exp_cnt);
    if (last) begin
      tick();
      chk("done_end", done, 0);
      chk("ready_end", in_ready, 1);
      chk("busy_end", busy, 0);
      m_hist = 0;
      m_seen = 0;
      m_first = 1;
    end
  endtask

  initial begin
    repeat (2) tick();
    reset = 0;
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pulse", match_pulse, 0);
    chk("rst_count", match_count, 0);
    chk("rst_ready2", in_ready2, 1);
    cfg(8'b1110, 4, 0);
    send_word(8'b0111_0111, 1, 1);
`ifdef PDC_STICKY_EN
    chk("sticky_set", sticky_match, 1);
    sticky_clr = 1;
    tick();
    sticky_clr = 0;
    chk("sticky_clr", sticky_match, 0);
`endif
    cfg(8'b11, 2, 1);
    send_word(8'hFF, 1, 7);
    cfg(8'b11, 2, 0);
    send_word(8'hFF, 1, 4);
    cfg(8'b1110, 4, 0);
    send_word(8'h07, 0, -1);
    send_word(8'h00, 1, 1);
    cfg(8'b1, 1, 1);
    send_word(8'hFF, 1, 8);
    chk("sat_count2", match_count2, 3);
    cfg(8'b1110, 4, 0);
    send_word(8'b0111_0111, 1, 1, 1);
    cfg(8'hFF, 12, 1);
    send_word(8'hFF, 1, 1);
    cfg(8'h00, 0, 0);
    send_word(8'h00, 1, 0);
    cfg(8'b1, 1, 1);
    in_valid = 1;
    in_data = 8'hFF;
    in_last = 1;
    tick();
    in_valid = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    m_hist = 0; m_seen = 0; m_pat = 0; m_len = 0; m_ovl = 0; m_first = 1; m_count = 0; m_count2 = 0;
    chk("abort_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_pulse", match_pulse, 0);
    chk("abort_count", match_count, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_no_done", done, 0);
    end
    send_word(8'hFF, 1, 0);
    cfg(8'b1110, 4, 0);
    send_word(8'b0111_0111, 1, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
